// File: rtl/core_br_pkg.sv
`default_nettype none
// core_br_pkg: branch funct3 encodings and the shared branch-condition decode.
// Revision: 1.0
package core_br_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  // Returns {taken, illegal}; lt must already reflect the signedness funct3[1] selects.
  function automatic logic [1:0] br_cond(input logic [2:0] funct3,
                                         input logic       eq,
                                         input logic       lt);
    logic [1:0] res;
    res = 2'b01;
    case (funct3)
      BR_BEQ:           res = {eq, 1'b0};
      BR_BNE:           res = {~eq, 1'b0};
      BR_BLT, BR_BLTU:  res = {lt, 1'b0};
      BR_BGE, BR_BGEU:  res = {~lt, 1'b0};
      default:          res = 2'b01;
    endcase
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/branch_resolve_unit_if.sv
`default_nettype none
// branch_resolve_unit_if: issue-side inputs and resolved-branch outputs of the branch stage.
// Revision: 1.0
interface branch_resolve_unit_if #(
  parameter int XLEN  = 32,
  parameter int NFWD  = 2,
  parameter int CNT_W = 16
);
  localparam int SELW = $clog2(NFWD + 1);

  logic                 in_valid;
  logic                 stall;
  logic                 flush;
  logic                 clr_cnt;
  logic [2:0]           funct3;
  logic                 pred_taken;
  logic [XLEN-1:0]      pc;
  logic [XLEN-1:0]      imm;
  logic [SELW-1:0]      fwd_sel_a;
  logic [SELW-1:0]      fwd_sel_b;
  logic [XLEN-1:0]      rf_rd1;
  logic [XLEN-1:0]      rf_rd2;
  logic [NFWD*XLEN-1:0] fwd_data;

  logic                 out_valid;
  logic                 br_eq;
  logic                 br_lt;
  logic                 br_taken;
  logic                 illegal;
  logic                 mispredict;
  logic [XLEN-1:0]      redirect_pc;
  logic [CNT_W-1:0]     branch_cnt;
  logic [CNT_W-1:0]     mispredict_cnt;

  modport master (
    output in_valid, stall, flush, clr_cnt, funct3, pred_taken, pc, imm,
           fwd_sel_a, fwd_sel_b, rf_rd1, rf_rd2, fwd_data,
    input  out_valid, br_eq, br_lt, br_taken, illegal, mispredict, redirect_pc,
           branch_cnt, mispredict_cnt
  );

  modport slave (
    input  in_valid, stall, flush, clr_cnt, funct3, pred_taken, pc, imm,
           fwd_sel_a, fwd_sel_b, rf_rd1, rf_rd2, fwd_data,
    output out_valid, br_eq, br_lt, br_taken, illegal, mispredict, redirect_pc,
           branch_cnt, mispredict_cnt
  );

endinterface
`default_nettype wire

// File: rtl/br_operand_mux.sv
`default_nettype none
// br_operand_mux: picks a branch operand from the register file or a forwarding slice.
// Revision: 1.0
module br_operand_mux #(
  parameter  int XLEN = 32,
  parameter  int NFWD = 2,
  localparam int SELW = $clog2(NFWD + 1)
) (
  input  wire logic [SELW-1:0]      sel,
  input  wire logic [XLEN-1:0]      rf_data,
  input  wire logic [NFWD*XLEN-1:0] fwd_data,
  output logic      [XLEN-1:0]      operand
);

  // Unused select codes above NFWD fall back to the register file value.
  always_comb begin
    operand = rf_data;
    for (int k = 1; k <= NFWD; k++) begin
      if (sel == SELW'(k)) begin
        operand = fwd_data[(k-1)*XLEN +: XLEN];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// branch_resolve_unit: registered branch compare, target, mispredict flag and statistics.
// Revision: 1.0
module branch_resolve_unit
  import core_br_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int NFWD  = 2,
  parameter int CNT_W = 16
) (
  input  wire logic            CLK,
  input  wire logic            RSTn,
  branch_resolve_unit_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [XLEN-1:0]  op_a;
  logic [XLEN-1:0]  op_b;
  logic             cmp_eq;
  logic             cmp_lt;
  logic             cond_taken;
  logic             cond_illegal;
  logic             cond_mispredict;
  logic [XLEN-1:0]  target;
  logic             load;

  logic             out_valid_q;
  logic             br_eq_q;
  logic             br_lt_q;
  logic             br_taken_q;
  logic             illegal_q;
  logic             mispredict_q;
  logic [XLEN-1:0]  redirect_pc_q;
  logic [CNT_W-1:0] branch_cnt_q;
  logic [CNT_W-1:0] mispredict_cnt_q;

  br_operand_mux #(.XLEN(XLEN), .NFWD(NFWD)) u_mux_a (
    .sel      (bus.fwd_sel_a),
    .rf_data  (bus.rf_rd1),
    .fwd_data (bus.fwd_data),
    .operand  (op_a)
  );

  br_operand_mux #(.XLEN(XLEN), .NFWD(NFWD)) u_mux_b (
    .sel      (bus.fwd_sel_b),
    .rf_data  (bus.rf_rd2),
    .fwd_data (bus.fwd_data),
    .operand  (op_b)
  );

  assign cmp_eq = (op_a == op_b);
  assign cmp_lt = bus.funct3[1] ? (op_a < op_b) : ($signed(op_a) < $signed(op_b));
  assign {cond_taken, cond_illegal} = br_cond(bus.funct3, cmp_eq, cmp_lt);
  assign cond_mispredict = ~cond_illegal & (cond_taken ^ bus.pred_taken);
  assign target = cond_taken ? (bus.pc + bus.imm) : (bus.pc + XLEN'(4));
  assign load   = bus.in_valid & ~bus.stall & ~bus.flush;

  // Flush only drops valid; the data fields keep their last loaded values.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      out_valid_q   <= 1'b0;
      br_eq_q       <= 1'b0;
      br_lt_q       <= 1'b0;
      br_taken_q    <= 1'b0;
      illegal_q     <= 1'b0;
      mispredict_q  <= 1'b0;
      redirect_pc_q <= '0;
    end else if (bus.flush) begin
      out_valid_q <= 1'b0;
    end else if (!bus.stall) begin
      out_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        br_eq_q       <= cmp_eq;
        br_lt_q       <= cmp_lt;
        br_taken_q    <= cond_taken;
        illegal_q     <= cond_illegal;
        mispredict_q  <= cond_mispredict;
        redirect_pc_q <= target;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTn || bus.clr_cnt) begin
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else if (load && !cond_illegal) begin
      if (branch_cnt_q != CNT_MAX) begin
        branch_cnt_q <= branch_cnt_q + CNT_W'(1);
      end
      if (cond_mispredict && (mispredict_cnt_q != CNT_MAX)) begin
        mispredict_cnt_q <= mispredict_cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.out_valid      = out_valid_q;
  assign bus.br_eq          = br_eq_q;
  assign bus.br_lt          = br_lt_q;
  assign bus.br_taken       = br_taken_q;
  assign bus.illegal        = illegal_q;
  assign bus.mispredict     = out_valid_q & mispredict_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.branch_cnt     = branch_cnt_q;
  assign bus.mispredict_cnt = mispredict_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// tb_branch_resolve_unit: directed scenarios plus random traffic against a behavioural model.
// Revision: 1.0
module tb_branch_resolve_unit;
  import core_br_pkg::*;

  localparam int XLEN  = 32;
  localparam int NFWD  = 2;
  localparam int CNT_W = 4;
  localparam int SELW  = 2;
  localparam logic [CNT_W-1:0] CMAX = 4'hF;

  logic CLK  = 1'b0;
  logic RSTn = 1'b0;
  always #5 CLK = ~CLK;

  branch_resolve_unit_if #(.XLEN(XLEN), .NFWD(NFWD), .CNT_W(CNT_W)) bus ();

  branch_resolve_unit #(.XLEN(XLEN), .NFWD(NFWD), .CNT_W(CNT_W)) dut (
    .CLK  (CLK),
    .RSTn (RSTn),
    .bus  (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  logic             m_valid = 1'b0, m_eq = 1'b0, m_lt = 1'b0, m_taken = 1'b0;
  logic             m_ill = 1'b0, m_mis = 1'b0;
  logic [XLEN-1:0]  m_pc   = '0;
  logic [CNT_W-1:0] m_bcnt = '0, m_mcnt = '0;

  function automatic logic [XLEN-1:0] pick(input logic [SELW-1:0] sel,
                                           input logic [XLEN-1:0] rf,
                                           input logic [NFWD*XLEN-1:0] fwd);
    int k;
    k = int'(sel);
    if (k >= 1 && k <= NFWD) return fwd[(k-1)*XLEN +: XLEN];
    return rf;
  endfunction

  // Reference behaviour of one clock edge, evaluated from the current inputs.
  task automatic model_edge();
    logic [XLEN-1:0] a, b;
    logic eq, ult, slt, tk, ill, mis;
    a   = pick(bus.fwd_sel_a, bus.rf_rd1, bus.fwd_data);
    b   = pick(bus.fwd_sel_b, bus.rf_rd2, bus.fwd_data);
    eq  = (a == b);
    ult = (a < b);
    slt = ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000));
    tk  = 1'b0;
    ill = 1'b0;
    case (bus.funct3)
      3'd0:    tk = eq;
      3'd1:    tk = !eq;
      3'd4:    tk = slt;
      3'd5:    tk = !slt;
      3'd6:    tk = ult;
      3'd7:    tk = !ult;
      default: ill = 1'b1;
    endcase
    mis = !ill && (tk != bus.pred_taken);
    if (!RSTn) begin
      m_valid = 0; m_eq = 0; m_lt = 0; m_taken = 0; m_ill = 0; m_mis = 0;
      m_pc = '0; m_bcnt = '0; m_mcnt = '0;
    end else begin
      if (bus.flush) m_valid = 1'b0;
      else if (!bus.stall) begin
        m_valid = bus.in_valid;
        if (bus.in_valid) begin
          m_eq    = eq;
          m_lt    = bus.funct3[1] ? ult : slt;
          m_taken = tk;
          m_ill   = ill;
          m_mis   = mis;
          m_pc    = tk ? bus.pc + bus.imm : bus.pc + 32'd4;
        end
      end
      if (bus.clr_cnt) begin
        m_bcnt = '0;
        m_mcnt = '0;
      end else if (bus.in_valid && !bus.stall && !bus.flush && !ill) begin
        if (m_bcnt != CMAX) m_bcnt = m_bcnt + 1'b1;
        if (mis && m_mcnt != CMAX) m_mcnt = m_mcnt + 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  function automatic logic [45:0] dut_vec();
    return {bus.out_valid, bus.br_eq, bus.br_lt, bus.br_taken, bus.illegal, bus.mispredict,
            bus.redirect_pc, bus.branch_cnt, bus.mispredict_cnt};
  endfunction

  function automatic logic [45:0] mdl_vec();
    return {m_valid, m_eq, m_lt, m_taken, m_ill, m_valid & m_mis, m_pc, m_bcnt, m_mcnt};
  endfunction

  task automatic idle();
    bus.in_valid = 0; bus.stall = 0; bus.flush = 0; bus.clr_cnt = 0;
    bus.funct3 = BR_BEQ; bus.pred_taken = 0; bus.pc = '0; bus.imm = '0;
    bus.fwd_sel_a = '0; bus.fwd_sel_b = '0; bus.rf_rd1 = '0; bus.rf_rd2 = '0;
    bus.fwd_data = '0;
  endtask

  task automatic set_br(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] pc, input logic [31:0] imm, input logic pred);
    bus.in_valid = 1; bus.funct3 = f3; bus.rf_rd1 = a; bus.rf_rd2 = b;
    bus.fwd_sel_a = '0; bus.fwd_sel_b = '0; bus.pc = pc; bus.imm = imm; bus.pred_taken = pred;
  endtask

  task automatic test_reset();
    idle();
    RSTn = 0;
    set_br(BR_BEQ, 32'h5, 32'h5, 32'h100, 32'h20, 1'b1);
    tick(); tick();
    tests_run++;
    if (dut_vec() !== 46'd0) begin
      tests_failed++; $display("FAIL reset_outputs: got %h want 0", dut_vec());
    end
    RSTn = 1;
    tick();
    tests_run++;
    if ({bus.out_valid, bus.br_eq, bus.br_taken, bus.mispredict} !== 4'b1110) begin
      tests_failed++;
      $display("FAIL beq_first: got %b want 1110", {bus.out_valid, bus.br_eq, bus.br_taken, bus.mispredict});
    end
    tests_run++;
    if (bus.redirect_pc !== 32'h120) begin
      tests_failed++; $display("FAIL beq_target: got %h want 00000120", bus.redirect_pc);
    end
  endtask

  task automatic test_signed_unsigned();
    set_br(BR_BLT, 32'hFFFF_FFFF, 32'h1, 32'h200, 32'h40, 1'b1);
    tick();
    tests_run++;
    if ({bus.br_lt, bus.br_taken} !== 2'b11) begin
      tests_failed++; $display("FAIL blt_signed: got %b want 11", {bus.br_lt, bus.br_taken});
    end
    set_br(BR_BLTU, 32'hFFFF_FFFF, 32'h1, 32'h200, 32'h40, 1'b0);
    tick();
    tests_run++;
    if ({bus.br_lt, bus.br_taken} !== 2'b00) begin
      tests_failed++; $display("FAIL bltu_unsigned: got %b want 00", {bus.br_lt, bus.br_taken});
    end
    set_br(BR_BGEU, 32'hFFFF_FFFF, 32'h1, 32'h200, 32'h40, 1'b1);
    tick();
    tests_run++;
    if ({bus.br_taken, bus.redirect_pc} !== {1'b1, 32'h240}) begin
      tests_failed++;
      $display("FAIL bgeu_target: got %b/%h want 1/00000240", bus.br_taken, bus.redirect_pc);
    end
  endtask

  task automatic test_forwarding();
    set_br(BR_BNE, 32'h9, 32'h9, 32'h300, 32'h8, 1'b1);
    bus.fwd_data  = {32'h7, 32'h3};
    bus.fwd_sel_a = 2'd1;
    bus.fwd_sel_b = 2'd2;
    tick();
    tests_run++;
    if ({bus.br_eq, bus.br_lt, bus.br_taken} !== 3'b011) begin
      tests_failed++; $display("FAIL fwd_slices: got %b want 011", {bus.br_eq, bus.br_lt, bus.br_taken});
    end
    bus.funct3 = BR_BEQ;
    bus.fwd_sel_a = 2'd3;
    bus.fwd_sel_b = 2'd0;
    tick();
    tests_run++;
    if ({bus.br_eq, bus.br_taken} !== 2'b11) begin
      tests_failed++; $display("FAIL fwd_out_of_range: got %b want 11", {bus.br_eq, bus.br_taken});
    end
    bus.fwd_sel_b = 2'd1;
    tick();
    tests_run++;
    if (dut_vec() !== mdl_vec()) begin
      tests_failed++; $display("FAIL fwd_mixed: got %h want %h", dut_vec(), mdl_vec());
    end
  endtask

  task automatic test_pipeline_control();
    logic [45:0] frozen;
    logic [CNT_W-1:0] bcnt_before;
    set_br(BR_BEQ, 32'h11, 32'h11, 32'h400, 32'h10, 1'b0);
    tick();
    frozen = mdl_vec();
    bus.stall = 1;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = ~bus.in_valid;
      bus.funct3 = (i == 1) ? BR_BNE : BR_BLTU;
      bus.rf_rd1 = $urandom;
      tick();
      tests_run++;
      if (dut_vec() !== frozen) begin
        tests_failed++; $display("FAIL stall_hold[%0d]: got %h want %h", i, dut_vec(), frozen);
      end
    end
    bus.in_valid = 1;
    bus.flush = 1;
    tick();
    tests_run++;
    if ({bus.out_valid, bus.mispredict} !== 2'b00) begin
      tests_failed++; $display("FAIL flush_over_stall: got %b want 00", {bus.out_valid, bus.mispredict});
    end
    bus.stall = 0;
    bus.flush = 0;
    bcnt_before = m_bcnt;
    set_br(3'b010, 32'h1, 32'h1, 32'h500, 32'h4, 1'b1);
    tick();
    tests_run++;
    if ({bus.out_valid, bus.illegal, bus.br_taken, bus.mispredict} !== 4'b1100) begin
      tests_failed++;
      $display("FAIL illegal_flags: got %b want 1100", {bus.out_valid, bus.illegal, bus.br_taken, bus.mispredict});
    end
    tests_run++;
    if (bus.branch_cnt !== bcnt_before) begin
      tests_failed++; $display("FAIL illegal_no_count: got %h want %h", bus.branch_cnt, bcnt_before);
    end
  endtask

  task automatic test_mispredict();
    idle();
    bus.clr_cnt = 1;
    tick();
    bus.clr_cnt = 0;
    set_br(BR_BEQ, 32'h2, 32'h2, 32'h600, 32'h30, 1'b0);
    tick();
    tests_run++;
    if ({bus.mispredict, bus.branch_cnt, bus.mispredict_cnt} !== {1'b1, 4'd1, 4'd1}) begin
      tests_failed++;
      $display("FAIL mispredict_count: got %b/%h/%h want 1/1/1", bus.mispredict, bus.branch_cnt, bus.mispredict_cnt);
    end
    set_br(BR_BNE, 32'h2, 32'h2, 32'hFFFF_FFFC, 32'h10, 1'b0);
    tick();
    tests_run++;
    if ({bus.br_taken, bus.redirect_pc} !== {1'b0, 32'h0}) begin
      tests_failed++; $display("FAIL pc_wrap: got %b/%h want 0/00000000", bus.br_taken, bus.redirect_pc);
    end
  endtask

  task automatic test_counters();
    idle();
    bus.clr_cnt = 1;
    tick();
    bus.clr_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      set_br(BR_BEQ, i, i, 32'h700 + 4 * i, 32'h40, 1'b0);
      tick();
    end
    tests_run++;
    if ({bus.branch_cnt, bus.mispredict_cnt} !== {CMAX, CMAX}) begin
      tests_failed++; $display("FAIL counter_saturate: got %h/%h want f/f", bus.branch_cnt, bus.mispredict_cnt);
    end
    bus.clr_cnt = 1;
    tick();
    bus.clr_cnt = 0;
    tests_run++;
    if ({bus.out_valid, bus.branch_cnt, bus.mispredict_cnt} !== {1'b1, 4'd0, 4'd0}) begin
      tests_failed++;
      $display("FAIL clr_with_branch: got %b/%h/%h want 1/0/0", bus.out_valid, bus.branch_cnt, bus.mispredict_cnt);
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int i = 0; i < 400; i++) begin
      RSTn          = ($urandom_range(0, 40) != 0);
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.stall     = ($urandom_range(0, 3) == 0);
      bus.flush     = ($urandom_range(0, 7) == 0);
      bus.clr_cnt   = ($urandom_range(0, 15) == 0);
      bus.funct3    = 3'($urandom);
      bus.pred_taken = 1'($urandom);
      bus.pc        = $urandom;
      bus.imm       = $urandom;
      bus.fwd_sel_a = 2'($urandom);
      bus.fwd_sel_b = 2'($urandom);
      a             = $urandom;
      bus.rf_rd1    = a;
      bus.rf_rd2    = ($urandom_range(0, 2) == 0) ? a : $urandom;
      bus.fwd_data  = ($urandom_range(0, 2) == 0) ? {a, a} : {$urandom, $urandom};
      tick();
      tests_run++;
      if (dut_vec() !== mdl_vec()) begin
        tests_failed++; $display("FAIL random[%0d]: got %h want %h", i, dut_vec(), mdl_vec());
      end
    end
    RSTn = 1;
  endtask

  initial begin
    test_reset();
    test_signed_unsigned();
    test_forwarding();
    test_pipeline_control();
    test_mispredict();
    test_counters();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
